// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: register widths and
// architectural register names.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_AT   = 5'd1;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: hardwired zero for register 0 and
// optional forwarding of the current-cycle write data.
module regfile_read_port
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              bypass_en,
  output logic [DATA_W-1:0] data
);

  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic hit;

  assign hit = bypass_en && we && (wa == addr);

  always_comb begin
    data = '0;
    if (addr != ZERO) begin
      if (hit) data = wd;
      else     data = word;
    end
  end

endmodule

// File: rtl/mips_regfile.sv
// 32-entry MIPS register file: two operand read ports with optional
// write bypass, one write-back port and an unbypassed debug port.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  // Register 0 has no storage; the read ports supply its zero.
  logic [DATA_W-1:0] regs [1:DEPTH-1];

  logic [DATA_W-1:0] rs_word;
  logic [DATA_W-1:0] rt_word;
  logic [DATA_W-1:0] dbg_word;
  logic              byp;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (we && wa != ZERO) begin
      regs[wa] <= wd;
    end
  end

  assign rs_word  = (rs_addr == ZERO) ? '0 : regs[rs_addr];
  assign rt_word  = (rt_addr == ZERO) ? '0 : regs[rt_addr];
  assign dbg_word = (dbg_addr == ZERO) ? '0 : regs[dbg_addr];

  // A write pending during reset is dropped, so it must not forward.
  assign byp = (BYPASS != 0) && !rst;

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rs (
    .addr      (rs_addr),
    .word      (rs_word),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .bypass_en (byp),
    .data      (rs_data)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rt (
    .addr      (rt_addr),
    .word      (rt_word),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .bypass_en (byp),
    .data      (rt_data)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dbg (
    .addr      (dbg_addr),
    .word      (dbg_word),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .bypass_en (1'b0),
    .data      (dbg_data)
  );

endmodule

// File: tb/tb_mips_regfile.sv
// Bench for mips_regfile: bypassed and unbypassed builds side by side,
// directed vector table then random traffic against a reference model.
module tb_mips_regfile;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data;
  logic [31:0] rs_data0, rt_data0, dbg_data0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model [32];

  mips_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data),
    .rt_addr  (rt_addr),
    .rt_data  (rt_data),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  mips_regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rs_data  (rs_data0),
    .rt_addr  (rt_addr),
    .rt_data  (rt_data0),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_dbg;
    logic [31:0] n_rs;
    logic [31:0] n_rt;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [4:0] a,
                       input logic [31:0] d, input logic [4:0] ra,
                       input logic [4:0] rb, input logic [4:0] rd);
    @(negedge clk);
    rst = r; we = w; wa = a; wd = d;
    rs_addr = ra; rt_addr = rb; dbg_addr = rd;
    #1;
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] ref_rd(input logic [4:0] a,
                                         input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && !rst && we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // rst we wa wd ra rb rd | rs rt dbg | nobyp rs rt
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 5, 32'hDEADBEEF, 5, REG_RA, 5,
                32'hDEADBEEF, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 5, REG_RA, 0,
                32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0};
    tbl[3]  = '{0, 0, 0, 0, 5, REG_RA, 5, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 7, 32'h12345678, 7, 6, 7,
                32'h12345678, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 7, 6, 7,
                32'h12345678, 0, 32'h12345678, 32'h12345678, 0};
    tbl[6]  = '{0, 1, 0, 32'hFFFFFFFF, 0, 7, 0,
                0, 32'h12345678, 0, 0, 32'h12345678};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 9, 32'h1, REG_AT, REG_AT, REG_AT, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 9, 32'hA5A5A5A5, 9, 9, 9,
                32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h1, 32'h1};
    tbl[10] = '{0, 0, 0, 0, 9, 9, 9,
                32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5,
                32'hA5A5A5A5, 32'hA5A5A5A5};
    tbl[11] = '{1, 1, REG_RA, 32'h55, REG_RA, REG_RA, REG_RA,
                0, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, REG_RA, 9, REG_RA, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 1, REG_SP, 32'hCAFEF00D, REG_SP, REG_RA, REG_SP,
                32'hCAFEF00D, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, REG_SP, REG_RA, REG_SP,
                32'hCAFEF00D, 0, 32'hCAFEF00D, 32'hCAFEF00D, 0};

    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].rst, tbl[k].we, tbl[k].wa, tbl[k].wd,
            tbl[k].ra, tbl[k].rb, tbl[k].rd);
      if (k > 0) begin
        chk($sformatf("v%0d rs", k), rs_data, tbl[k].e_rs);
        chk($sformatf("v%0d rt", k), rt_data, tbl[k].e_rt);
        chk($sformatf("v%0d dbg", k), dbg_data, tbl[k].e_dbg);
        chk($sformatf("v%0d rs0", k), rs_data0, tbl[k].n_rs);
        chk($sformatf("v%0d rt0", k), rt_data0, tbl[k].n_rt);
        chk($sformatf("v%0d dbg0", k), dbg_data0, tbl[k].e_dbg);
      end
    end

    // Reset held over two edges with a write pending, then a normal write.
    drive(1, 1, 3, 32'h77, 3, 3, 3);
    drive(1, 1, 3, 32'h88, 3, 3, 3);
    chk("hold rs", rs_data, 32'h0);
    chk("hold dbg", dbg_data, 32'h0);
    drive(0, 1, 3, 32'h99, 3, REG_SP, 3);
    chk("post-rst byp", rs_data, 32'h99);
    chk("post-rst sp", rt_data, 32'h0);
    chk("post-rst dbg", dbg_data, 32'h0);
    drive(0, 0, 0, 0, 3, 3, 3);
    chk("post-rst wr", rs_data, 32'h99);
    chk("post-rst wr0", rt_data0, 32'h99);

    // Synchronise the model with a reset, then random traffic.
    drive(1, 0, 0, 0, 0, 0, 0);
    model_edge();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 24) == 0), $urandom_range(0, 1),
            5'($urandom), $urandom, 5'($urandom),
            ($urandom_range(0, 3) == 0) ? wa : 5'($urandom),
            5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        rs_addr = wa;
        #1;
      end
      chk("rnd rs", rs_data, ref_rd(rs_addr, 1'b1));
      chk("rnd rt", rt_data, ref_rd(rt_addr, 1'b1));
      chk("rnd dbg", dbg_data, ref_rd(dbg_addr, 1'b0));
      chk("rnd rs0", rs_data0, ref_rd(rs_addr, 1'b0));
      chk("rnd rt0", rt_data0, ref_rd(rt_addr, 1'b0));
      chk("rnd dbg0", dbg_data0, ref_rd(dbg_addr, 1'b0));
      @(posedge clk);
      model_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
